// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART loopback/FIFO glue.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Routing mode; encoding 2'd3 is unused and treated as EXTERNAL.
    typedef enum logic [1:0] {
        MODE_EXTERNAL = 2'd0,
        MODE_LOOPBACK = 2'd1,
        MODE_DRAIN    = 2'd2
    } mode_e;

endpackage

// File: rtl/uart_loopback_fifo_if.sv
// Ready/ack handshake bundle between the UART core, the glue and the host.
// The slave modport is the glue's view; master is the surrounding system.
interface uart_loopback_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] uart_rx_data_i;
    logic                  uart_rx_ready_i;
    logic                  uart_rx_ack_o;
    logic [DATA_WIDTH-1:0] uart_tx_data_o;
    logic                  uart_tx_ready_o;
    logic                  uart_tx_ack_i;
    logic [DATA_WIDTH-1:0] host_rx_data_o;
    logic                  host_rx_ready_o;
    logic                  host_rx_ack_i;
    logic [DATA_WIDTH-1:0] host_tx_data_i;
    logic                  host_tx_ready_i;
    logic                  host_tx_ack_o;

    modport slave (
        input  uart_rx_data_i, uart_rx_ready_i, uart_tx_ack_i,
        input  host_rx_ack_i, host_tx_data_i, host_tx_ready_i,
        output uart_rx_ack_o, uart_tx_data_o, uart_tx_ready_o,
        output host_rx_data_o, host_rx_ready_o, host_tx_ack_o
    );

    modport master (
        output uart_rx_data_i, uart_rx_ready_i, uart_tx_ack_i,
        output host_rx_ack_i, host_tx_data_i, host_tx_ready_i,
        input  uart_rx_ack_o, uart_tx_data_o, uart_tx_ready_o,
        input  host_rx_data_o, host_rx_ready_o, host_tx_ack_o
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
// Push while full and pop while empty are ignored.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array: written at wptr on an accepted push.
    // NOTE: the array is reset because stale bytes must never be visible on
    // rdata after reset; this costs a reset net per storage bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap by natural overflow; level tracks occupancy explicitly.
    // NOTE: non-blocking assignments here so every flop samples pre-edge
    // values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// Routes UART RX/TX handshakes either to the host port or through an
// internal echo FIFO, with an orderly drain when leaving loopback.
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH          = 4,
    parameter  int DROP_WHEN_FULL = 0,
    parameter  int CNT_WIDTH      = 8,
    localparam int LVL_W          = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 loopback_i,
    uart_loopback_fifo_if.slave  bus,
    output logic [LVL_W-1:0]     level_o,
    output logic [CNT_WIDTH-1:0] overflow_count_o,
    output logic [1:0]           state_o
);

    localparam logic DROP = (DROP_WHEN_FULL != 0);

    mode_e                 state;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_byte;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [LVL_W-1:0]      fifo_level;

    // Pushes only depend on registered state, so uart_tx_ack_i never reaches
    // uart_rx_ack_o combinationally.
    assign fifo_push = (state == MODE_LOOPBACK) && bus.uart_rx_ready_i && !fifo_full;
    assign drop_byte = DROP && (state == MODE_LOOPBACK) && bus.uart_rx_ready_i && fifo_full;
    assign fifo_pop  = ((state == MODE_LOOPBACK) || (state == MODE_DRAIN))
                       && !fifo_empty && bus.uart_tx_ack_i;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus.uart_rx_data_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign level_o = fifo_level;
    assign state_o = state;

    // Handshake routing per mode; everything is held low while reset is high.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        bus.uart_rx_ack_o   = 1'b0;
        bus.uart_tx_ready_o = 1'b0;
        bus.uart_tx_data_o  = '0;
        bus.host_rx_ready_o = 1'b0;
        bus.host_rx_data_o  = '0;
        bus.host_tx_ack_o   = 1'b0;
        if (!reset) begin
            case (state)
                MODE_EXTERNAL: begin
                    bus.host_rx_ready_o = bus.uart_rx_ready_i;
                    bus.host_rx_data_o  = bus.uart_rx_data_i;
                    bus.uart_rx_ack_o   = bus.host_rx_ack_i;
                    bus.uart_tx_ready_o = bus.host_tx_ready_i;
                    bus.uart_tx_data_o  = bus.host_tx_data_i;
                    bus.host_tx_ack_o   = bus.uart_tx_ack_i;
                end
                MODE_LOOPBACK: begin
                    bus.uart_rx_ack_o   = bus.uart_rx_ready_i && (!fifo_full || DROP);
                    bus.uart_tx_ready_o = !fifo_empty;
                    bus.uart_tx_data_o  = fifo_rdata;
                end
                MODE_DRAIN: begin
                    bus.host_rx_ready_o = bus.uart_rx_ready_i;
                    bus.host_rx_data_o  = bus.uart_rx_data_i;
                    bus.uart_rx_ack_o   = bus.host_rx_ack_i;
                    bus.uart_tx_ready_o = !fifo_empty;
                    bus.uart_tx_data_o  = fifo_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Mode FSM. In DRAIN a loopback request takes priority over finishing
    // the drain, so the remaining bytes keep echoing in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MODE_EXTERNAL;
        end else begin
            case (state)
                MODE_EXTERNAL: begin
                    if (loopback_i) begin
                        state <= MODE_LOOPBACK;
                    end
                end
                MODE_LOOPBACK: begin
                    if (!loopback_i) begin
                        state <= fifo_empty ? MODE_EXTERNAL : MODE_DRAIN;
                    end
                end
                MODE_DRAIN: begin
                    if (loopback_i) begin
                        state <= MODE_LOOPBACK;
                    end else if (fifo_empty || ((fifo_level == LVL_W'(1)) && fifo_pop)) begin
                        state <= MODE_EXTERNAL;
                    end
                end
                default: state <= MODE_EXTERNAL;
            endcase
        end
    end

    // Saturating count of bytes acked and discarded while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_count_o <= '0;
        end else if (drop_byte && (overflow_count_o != '1)) begin
            overflow_count_o <= overflow_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Bench for uart_loopback_fifo: two instances (backpressure / drop with a
// 2-bit counter) share one stimulus stream. A queue-based reference model
// predicts handshakes each cycle and feeds scoreboards that a separate
// monitor drains on every observed transfer.
module tb_uart_loopback_fifo;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    typedef struct {
        int          inst;
        logic [DW-1:0] data;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          loopback;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic          tx_ack;
    logic          host_rx_ack;
    logic [DW-1:0] host_tx_data;
    logic          host_tx_ready;

    always #5 clk = ~clk;

    uart_loopback_fifo_if #(.DATA_WIDTH(DW)) bus0 ();
    uart_loopback_fifo_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.uart_rx_data_i  = rx_data;
    assign bus0.uart_rx_ready_i = rx_ready;
    assign bus0.uart_tx_ack_i   = tx_ack;
    assign bus0.host_rx_ack_i   = host_rx_ack;
    assign bus0.host_tx_data_i  = host_tx_data;
    assign bus0.host_tx_ready_i = host_tx_ready;
    assign bus1.uart_rx_data_i  = rx_data;
    assign bus1.uart_rx_ready_i = rx_ready;
    assign bus1.uart_tx_ack_i   = tx_ack;
    assign bus1.host_rx_ack_i   = host_rx_ack;
    assign bus1.host_tx_data_i  = host_tx_data;
    assign bus1.host_tx_ready_i = host_tx_ready;

    logic [LW-1:0] level0, level1;
    logic [7:0]    cnt0;
    logic [1:0]    cnt1;
    logic [1:0]    state0, state1;

    uart_loopback_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_WHEN_FULL(0), .CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .reset(reset), .loopback_i(loopback), .bus(bus0.slave),
        .level_o(level0), .overflow_count_o(cnt0), .state_o(state0)
    );

    uart_loopback_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_WHEN_FULL(1), .CNT_WIDTH(2)
    ) dut1 (
        .clk(clk), .reset(reset), .loopback_i(loopback), .bus(bus1.slave),
        .level_o(level1), .overflow_count_o(cnt1), .state_o(state1)
    );

    // Per-instance views of the outputs so checks can be indexed.
    logic          o_rx_ack [2];
    logic          o_tx_ready [2];
    logic          o_hrx_ready [2];
    logic          o_htx_ack [2];
    logic [DW-1:0] o_tx_data [2];
    logic [DW-1:0] o_hrx_data [2];
    logic [LW-1:0] o_level [2];
    logic [7:0]    o_cnt [2];
    logic [1:0]    o_state [2];

    assign o_rx_ack[0]    = bus0.uart_rx_ack_o;
    assign o_rx_ack[1]    = bus1.uart_rx_ack_o;
    assign o_tx_ready[0]  = bus0.uart_tx_ready_o;
    assign o_tx_ready[1]  = bus1.uart_tx_ready_o;
    assign o_hrx_ready[0] = bus0.host_rx_ready_o;
    assign o_hrx_ready[1] = bus1.host_rx_ready_o;
    assign o_htx_ack[0]   = bus0.host_tx_ack_o;
    assign o_htx_ack[1]   = bus1.host_tx_ack_o;
    assign o_tx_data[0]   = bus0.uart_tx_data_o;
    assign o_tx_data[1]   = bus1.uart_tx_data_o;
    assign o_hrx_data[0]  = bus0.host_rx_data_o;
    assign o_hrx_data[1]  = bus1.host_rx_data_o;
    assign o_level[0]     = level0;
    assign o_level[1]     = level1;
    assign o_cnt[0]       = cnt0;
    assign o_cnt[1]       = {6'b0, cnt1};
    assign o_state[0]     = state0;
    assign o_state[1]     = state1;

    // Reference model: mode 0 external, 1 loopback, 2 drain; FIFO as an
    // ordered list where element 0 is the oldest byte.
    int            m_mode [2];
    int            m_cnt [2];
    int            m_ovf [2];
    logic [DW-1:0] m_buf [2][DEPTH];

    sb_t sb_tx[$];
    sb_t sb_host[$];

    int errors = 0;
    int checks = 0;

    function automatic bit drop_of(input int k);
        return k == 1;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 1) ? 3 : 255;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_cnt[k]  = 0;
            m_ovf[k]  = 0;
            for (int i = 0; i < DEPTH; i++) m_buf[k][i] = '0;
        end
        sb_tx.delete();
        sb_host.delete();
    endtask

    // Predict this cycle's handshakes from the current inputs, queue the
    // expected transfers, then advance the model to the next cycle.
    task automatic model_step(input int k);
        bit ext, lbk, full, push, pop, drop;
        int c0, nxt;
        ext  = (m_mode[k] == 0);
        lbk  = (m_mode[k] == 1);
        c0   = m_cnt[k];
        full = (c0 == DEPTH);

        check("uart_rx_ack", k, 32'(o_rx_ack[k]),
              32'(lbk ? (rx_ready && (!full || drop_of(k))) : host_rx_ack));
        check("uart_tx_ready", k, 32'(o_tx_ready[k]), 32'(ext ? host_tx_ready : (c0 != 0)));
        check("host_rx_ready", k, 32'(o_hrx_ready[k]), 32'(lbk ? 1'b0 : rx_ready));
        check("host_tx_ack", k, 32'(o_htx_ack[k]), 32'(ext ? tx_ack : 1'b0));
        check("level", k, 32'(o_level[k]), 32'(c0));
        check("state", k, 32'(o_state[k]), 32'(m_mode[k]));
        check("overflow_count", k, 32'(o_cnt[k]), 32'(m_ovf[k]));
        if (!lbk && rx_ready) check("host_rx_data", k, 32'(o_hrx_data[k]), 32'(rx_data));
        if (ext && host_tx_ready) check("tx_pass_data", k, 32'(o_tx_data[k]), 32'(host_tx_data));
        if (!ext && c0 != 0) check("tx_fifo_data", k, 32'(o_tx_data[k]), 32'(m_buf[k][0]));

        push = lbk && rx_ready && !full;
        drop = lbk && rx_ready && full && drop_of(k);
        pop  = !ext && (c0 != 0) && tx_ack;

        if (!lbk && rx_ready && host_rx_ack) sb_host.push_back('{k, rx_data});
        if (ext && host_tx_ready && tx_ack) sb_tx.push_back('{k, host_tx_data});
        if (pop) begin
            sb_tx.push_back('{k, m_buf[k][0]});
            for (int i = 0; i < DEPTH - 1; i++) m_buf[k][i] = m_buf[k][i+1];
            m_cnt[k]--;
        end
        if (push) begin
            m_buf[k][m_cnt[k]] = rx_data;
            m_cnt[k]++;
        end
        if (drop && m_ovf[k] < cnt_max(k)) m_ovf[k]++;

        nxt = m_mode[k];
        case (m_mode[k])
            0: if (loopback) nxt = 1;
            1: if (!loopback) nxt = (c0 == 0) ? 0 : 2;
            default: begin
                if (loopback) nxt = 1;
                else if (c0 == 0 || (c0 == 1 && pop)) nxt = 0;
            end
        endcase
        m_mode[k] = nxt;
    endtask

    task automatic cycle(input logic lb, input logic rxr, input logic [DW-1:0] rxd,
                         input logic txa, input logic hra, input logic htr,
                         input logic [DW-1:0] htd);
        @(negedge clk);
        loopback      = lb;
        rx_ready      = rxr;
        rx_data       = rxd;
        tx_ack        = txa;
        host_rx_ack   = hra;
        host_tx_ready = htr;
        host_tx_data  = htd;
        #1;
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input logic lb);
        cycle(lb, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check("rst_rx_ack", k, 32'(o_rx_ack[k]), 32'(0));
            check("rst_tx_ready", k, 32'(o_tx_ready[k]), 32'(0));
            check("rst_host_rx_ready", k, 32'(o_hrx_ready[k]), 32'(0));
            check("rst_host_tx_ack", k, 32'(o_htx_ack[k]), 32'(0));
            check("rst_tx_data", k, 32'(o_tx_data[k]), 32'(0));
            check("rst_host_rx_data", k, 32'(o_hrx_data[k]), 32'(0));
            check("rst_level", k, 32'(o_level[k]), 32'(0));
            check("rst_count", k, 32'(o_cnt[k]), 32'(0));
            check("rst_state", k, 32'(o_state[k]), 32'(MODE_EXTERNAL));
        end
    endtask

    task automatic pop_tx(input int k);
        int idx = -1;
        foreach (sb_tx[i]) if (idx < 0 && sb_tx[i].inst == k) idx = i;
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL tx_transfer dut%0d: got byte %0h expected no transfer at %0t",
                     k, o_tx_data[k], $time);
        end else begin
            check("tx_transfer_data", k, 32'(o_tx_data[k]), 32'(sb_tx[idx].data));
            sb_tx.delete(idx);
        end
    endtask

    task automatic pop_host(input int k);
        int idx = -1;
        foreach (sb_host[i]) if (idx < 0 && sb_host[i].inst == k) idx = i;
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL host_rx_transfer dut%0d: got byte %0h expected no transfer at %0t",
                     k, o_hrx_data[k], $time);
        end else begin
            check("host_rx_transfer_data", k, 32'(o_hrx_data[k]), 32'(sb_host[idx].data));
            sb_host.delete(idx);
        end
    endtask

    // Monitor: on every observed transfer, retire the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                for (int k = 0; k < 2; k++) begin
                    if (o_tx_ready[k] && tx_ack) pop_tx(k);
                    if (o_hrx_ready[k] && host_rx_ack) pop_host(k);
                end
            end
        end
    end

    initial begin
        logic lb_r;
        int   tx_p;

        // Reset with all inputs asserted: outputs must stay low.
        reset = 1'b1;
        loopback = 1'b0; rx_ready = 1'b1; rx_data = 8'hFF; tx_ack = 1'b1;
        host_rx_ack = 1'b1; host_tx_ready = 1'b1; host_tx_data = 8'hFF;
        model_reset();
        #2;
        check_reset_outputs();
        rx_ready = 1'b0; tx_ack = 1'b0; host_rx_ack = 1'b0; host_tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Two echoed bytes held, then released in order.
        idle(1'b1);
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1'b1);
        check("tp_level_two", 0, 32'(o_level[0]), 32'(2));
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tp_first_echo", 0, 32'(o_tx_data[0]), 32'(8'h55));
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tp_second_echo", 0, 32'(o_tx_data[0]), 32'(8'hA3));
        idle(1'b1);
        check("tp_level_zero", 0, 32'(o_level[0]), 32'(0));

        // Overfill: backpressure on dut0, drop-and-count on dut1.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 8'h00);
            if (i == 4) begin
                check("tp_fifth_unacked", 0, 32'(o_rx_ack[0]), 32'(0));
                check("tp_fifth_dropped", 1, 32'(o_rx_ack[1]), 32'(1));
            end
        end
        idle(1'b1);
        check("tp_full_level", 0, 32'(o_level[0]), 32'(4));
        check("tp_no_overflow", 0, 32'(o_cnt[0]), 32'(0));
        check("tp_count_saturated", 1, 32'(o_cnt[1]), 32'(3));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
            check("tp_contents_kept", 1, 32'(o_tx_data[1]), 32'(8'h10 + i));
        end

        // Drain: host TX is blocked until the FIFO empties.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7E);
            check("tp_drain_state", 0, 32'(o_state[0]), 32'(MODE_DRAIN));
            check("tp_drain_host_blocked", 0, 32'(o_htx_ack[0]), 32'(0));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7E);
        check("tp_back_external", 0, 32'(o_state[0]), 32'(MODE_EXTERNAL));
        check("tp_host_byte_through", 0, 32'(o_tx_data[0]), 32'(8'h7E));

        // External RX pass-through.
        cycle(1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 8'h00);
        check("tp_host_rx_data", 0, 32'(o_hrx_data[0]), 32'(8'h31));
        check("tp_rx_ack_through", 0, 32'(o_rx_ack[0]), 32'(1));

        // Asynchronous reset with two bytes held in loopback.
        idle(1'b1);
        cycle(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(1'b1);
        check("tp_pre_reset_level", 0, 32'(o_level[0]), 32'(2));
        reset = 1'b1;
        rx_ready = 1'b1; tx_ack = 1'b1; host_rx_ack = 1'b1; host_tx_ready = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        rx_ready = 1'b0; tx_ack = 1'b0; host_rx_ack = 1'b0; host_tx_ready = 1'b0;
        loopback = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Randomised traffic with varying transmitter acceptance rates.
        lb_r = 1'b1;
        tx_p = 50;
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) tx_p = $urandom_range(0, 100);
            if ($urandom_range(0, 99) < 4) lb_r = ~lb_r;
            cycle(lb_r, 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 99) < tx_p), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle(1'b0);
        #5;
        check("tx_scoreboard_empty", 0, 32'(sb_tx.size()), 32'(0));
        check("host_scoreboard_empty", 0, 32'(sb_host.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
- Parametrised successor to the single-byte loopback glue that sits between the UART core and its consumer.
- Routes UART RX/TX handshakes either to an external host port or through an internal DEPTH-entry FIFO that echoes received data back out of TX.
- Adds mode switching with orderly drain, a full-policy option, a fill-level readout and a saturating overflow counter.

Parameters:
- DATA_WIDTH, 8, width of each character.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DROP_WHEN_FULL, 0, 0 = backpressure RX when full; 1 = ack and discard the byte, counting it.
- CNT_WIDTH, 8, width of the overflow counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- loopback_i  in  1  1 requests loopback mode, 0 requests external mode.
- uart_rx_data_i  in  DATA_WIDTH  byte from UART receiver.
- uart_rx_ready_i  in  1  receiver holds a valid byte.
- uart_rx_ack_o  out  1  one-cycle consume strobe to receiver.
- uart_tx_data_o  out  DATA_WIDTH  byte to UART transmitter.
- uart_tx_ready_o  out  1  byte offered to transmitter.
- uart_tx_ack_i  in  1  transmitter took the byte this cycle.
- host_rx_data_o  out  DATA_WIDTH  received byte toward host.
- host_rx_ready_o  out  1  byte offered to host.
- host_rx_ack_i  in  1  host consumed byte.
- host_tx_data_i  in  DATA_WIDTH  host byte to transmit.
- host_tx_ready_i  in  1  host offers a byte.
- host_tx_ack_o  out  1  host byte taken this cycle.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow_count_o  out  CNT_WIDTH  dropped-byte count, saturating.
- state_o  out  2  current mode: 0 EXTERNAL, 1 LOOPBACK, 2 DRAIN.

Behaviour:
- Reset (async): state EXTERNAL, pointers 0, level_o 0, overflow_count_o 0, FIFO contents 0. All ack/ready outputs are 0 while reset is high.
- Handshake rule: a transfer occurs in the cycle where ready and ack are both high. Acks are combinational from ready and internal state. No combinational path from uart_tx_ack_i to uart_rx_ack_o.
- EXTERNAL:
  - host_rx_* and uart_rx_ack_o pass straight through to/from uart_rx_*.
  - uart_tx_* and host_tx_ack_o pass straight through to/from host_tx_*.
  - FIFO is idle.
- LOOPBACK:
  - host_rx_ready_o = 0 and host_tx_ack_o = 0.
  - Push: uart_rx_ack_o = uart_rx_ready_i && (level < DEPTH); the byte is written at wptr and wptr increments.
  - Full with DROP_WHEN_FULL = 1: uart_rx_ack_o = uart_rx_ready_i; the byte is discarded and the counter increments, saturating at all-ones.
  - Pop: uart_tx_ready_o = (level != 0); uart_tx_data_o = mem[rptr]; on uart_tx_ack_i, rptr increments.
  - Push and pop in the same cycle: level is unchanged. A full FIFO never accepts a push, even when a pop occurs in the same cycle.
- DRAIN:
  - RX path is routed to the host (pass-through, as in EXTERNAL); no further pushes.
  - TX is served from the FIFO as in LOOPBACK; host_tx_ack_o = 0.
- Transitions (registered, take effect next cycle):
  - EXTERNAL -> LOOPBACK when loopback_i = 1.
  - LOOPBACK -> DRAIN when loopback_i = 0 and level != 0.
  - LOOPBACK -> EXTERNAL when loopback_i = 0 and level = 0.
  - DRAIN -> EXTERNAL when level = 0, or when level = 1 and a pop occurs this cycle.
  - DRAIN -> LOOPBACK when loopback_i = 1.
  - Encoding 3 is illegal and recovers to EXTERNAL.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level_o is a separate counter.
- Reset asserted mid-transfer discards FIFO contents; any byte in flight is lost.

Decomposition:
- Package uart_pkg holds the mode enum (MODE_EXTERNAL, MODE_LOOPBACK, MODE_DRAIN) and the shared default DATA_WIDTH.
- One sub-module, uart_sync_fifo (DATA_WIDTH, DEPTH): push/pop/full/empty/level. The mode FSM and routing muxes stay in the top.

Test Plan:
- LOOPBACK, DEPTH = 4: receive 0x55, 0xA3 with uart_tx_ack_i held low -> level_o = 2; then ack twice -> tx emits 0x55 then 0xA3, level_o = 0.
- LOOPBACK, DROP_WHEN_FULL = 0: 5 bytes offered, no tx acks -> 4 acked, 5th ready stays unacked, level_o = 4, overflow_count_o = 0.
- LOOPBACK, DROP_WHEN_FULL = 1, CNT_WIDTH = 2: fill to 4, then offer 5 more -> all acked, count saturates at 3, FIFO contents unchanged.
- Fill 3 bytes, drop loopback_i -> state DRAIN, host_tx_ack_o = 0 despite host_tx_ready_i; after 3 tx acks -> state EXTERNAL; next host byte 0x7E passes through.
- EXTERNAL: uart_rx 0x31 ready -> host_rx_data_o = 0x31 same cycle; host_rx_ack_i -> uart_rx_ack_o high in that cycle.
- Assert reset while level_o = 2 in LOOPBACK -> all outputs 0, state EXTERNAL immediately (async), overflow_count_o = 0.
